// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between two RW requesters, one read-only requester and a dual-port SRAM macro.
// The master side drives requests and SRAM read data; the slave side is the arbiter.
interface sram_port_arbiter_if #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 8,
    parameter int NUM_WMASKS = 4
);
    logic                  m0_req, m1_req;
    logic                  m0_we, m1_we;
    logic [NUM_WMASKS-1:0] m0_wmask, m1_wmask;
    logic [ADDR_W-1:0]     m0_addr, m1_addr;
    logic [DATA_W-1:0]     m0_wdata, m1_wdata;
    logic                  m0_gnt, m1_gnt;
    logic                  m0_rvalid, m1_rvalid;
    logic [DATA_W-1:0]     m0_rdata, m1_rdata;

    logic                  r_req;
    logic [ADDR_W-1:0]     r_addr;
    logic                  r_gnt;
    logic                  r_rvalid;
    logic [DATA_W-1:0]     r_rdata;

    logic                  sram_csb0, sram_web0;
    logic [NUM_WMASKS-1:0] sram_wmask0;
    logic [ADDR_W-1:0]     sram_addr0;
    logic [DATA_W-1:0]     sram_din0;
    logic [DATA_W-1:0]     sram_dout0;
    logic                  sram_csb1;
    logic [ADDR_W-1:0]     sram_addr1;
    logic [DATA_W-1:0]     sram_dout1;

    logic [7:0]            stall_cnt;

    modport master (
        output m0_req, m1_req, m0_we, m1_we, m0_wmask, m1_wmask,
        output m0_addr, m1_addr, m0_wdata, m1_wdata, r_req, r_addr,
        output sram_dout0, sram_dout1,
        input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
        input  r_gnt, r_rvalid, r_rdata,
        input  sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0,
        input  sram_csb1, sram_addr1, stall_cnt
    );

    modport slave (
        input  m0_req, m1_req, m0_we, m1_we, m0_wmask, m1_wmask,
        input  m0_addr, m1_addr, m0_wdata, m1_wdata, r_req, r_addr,
        input  sram_dout0, sram_dout1,
        output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
        output r_gnt, r_rvalid, r_rdata,
        output sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0,
        output sram_csb1, sram_addr1, stall_cnt
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter for SRAM port 0 (two RW requesters) plus a read-only requester on
// port 1 that stalls on same-address port-0 writes and is forced through after two stalls.
module sram_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 8,
    parameter int NUM_WMASKS = 4
) (
    input  logic               clk,
    input  logic               rstn,
    sram_port_arbiter_if.slave bus
);
    logic [1:0]            req, we, blocked, eligible, gnt;
    logic [ADDR_W-1:0]     addr_arr  [2];
    logic [DATA_W-1:0]     wdata_arr [2];
    logic [NUM_WMASKS-1:0] wmask_arr [2];

    logic       sel, p0_active, p0_we, conflict, force_r, r_gnt;
    logic       rr_reg, rr_next;
    logic [1:0] rvalid_reg;
    logic       r_rvalid_reg;
    logic [1:0] stall_run_reg, stall_run_next;
    logic [7:0] stall_cnt_reg, stall_cnt_next;

    assign req          = {bus.m1_req, bus.m0_req};
    assign we           = {bus.m1_we, bus.m0_we};
    assign addr_arr[0]  = bus.m0_addr;
    assign addr_arr[1]  = bus.m1_addr;
    assign wdata_arr[0] = bus.m0_wdata;
    assign wdata_arr[1] = bus.m1_wdata;
    assign wmask_arr[0] = bus.m0_wmask;
    assign wmask_arr[1] = bus.m1_wmask;

    // Once the reader has stalled twice in a row, same-address writes are held off for a cycle.
    assign force_r = bus.r_req & (stall_run_reg >= 2'd2);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign blocked[gi]  = force_r & req[gi] & we[gi] & (addr_arr[gi] == bus.r_addr);
            assign eligible[gi] = req[gi] & ~blocked[gi];
        end
    endgenerate

    always_comb begin
        gnt = 2'b00;
        if (rstn) begin
            if (eligible == 2'b11) gnt = rr_reg ? 2'b10 : 2'b01;
            else                   gnt = eligible;
        end
    end

    assign sel       = gnt[1];
    assign p0_active = |gnt;
    assign p0_we     = p0_active & we[sel];
    assign conflict  = bus.r_req & p0_we & (addr_arr[sel] == bus.r_addr);
    assign r_gnt     = rstn & bus.r_req & ~conflict;

    assign bus.m0_gnt      = gnt[0];
    assign bus.m1_gnt      = gnt[1];
    assign bus.r_gnt       = r_gnt;
    assign bus.sram_csb0   = ~p0_active;
    assign bus.sram_web0   = ~p0_we;
    assign bus.sram_wmask0 = wmask_arr[sel];
    assign bus.sram_addr0  = addr_arr[sel];
    assign bus.sram_din0   = wdata_arr[sel];
    assign bus.sram_csb1   = ~r_gnt;
    assign bus.sram_addr1  = bus.r_addr;

    assign bus.m0_rvalid = rvalid_reg[0];
    assign bus.m1_rvalid = rvalid_reg[1];
    assign bus.m0_rdata  = bus.sram_dout0;
    assign bus.m1_rdata  = bus.sram_dout0;
    assign bus.r_rvalid  = r_rvalid_reg;
    assign bus.r_rdata   = bus.sram_dout1;
    assign bus.stall_cnt = stall_cnt_reg;

    always_comb begin
        rr_next = rr_reg;
        if (gnt[0])      rr_next = 1'b1;
        else if (gnt[1]) rr_next = 1'b0;

        stall_run_next = stall_run_reg;
        if (!bus.r_req || r_gnt)                   stall_run_next = 2'd0;
        else if (conflict && stall_run_reg != 2'd3) stall_run_next = stall_run_reg + 2'd1;

        stall_cnt_next = stall_cnt_reg;
        if (conflict && stall_cnt_reg != 8'hFF) stall_cnt_next = stall_cnt_reg + 8'd1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_reg        <= 1'b0;
            rvalid_reg    <= 2'b00;
            r_rvalid_reg  <= 1'b0;
            stall_run_reg <= 2'd0;
            stall_cnt_reg <= 8'd0;
        end else begin
            rr_reg        <= rr_next;
            rvalid_reg    <= gnt & ~we;
            r_rvalid_reg  <= r_gnt;
            stall_run_reg <= stall_run_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end
endmodule
